// File: rtl/vc_input_buffer.sv
// Multi-VC router input buffer: NUM_VC independent circular FIFOs behind one
// write port and one registered read port, with credit return and sticky error flags.

module vc_input_buffer_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 5,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CNT_W-1:0]      count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wptr, rptr;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk)
    if (wr_en) mem[wptr] <= wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= ptr_inc(wptr);
      if (rd_en) rptr <= ptr_inc(rptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rptr];
endmodule

module vc_input_buffer #(
  parameter  int DATA_WIDTH = 16,
  parameter  int DEPTH      = 5,
  parameter  int NUM_VC     = 2,
  localparam int VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    buf_write_i,
  input  logic [VC_W-1:0]         buf_wvc_i,
  input  logic [DATA_WIDTH-1:0]   buf_data_i,
  input  logic                    buf_read_i,
  input  logic [VC_W-1:0]         buf_rvc_i,
  output logic [DATA_WIDTH-1:0]   buf_data_o,
  output logic                    buf_valid_o,
  output logic [NUM_VC-1:0]       buf_empty_o,
  output logic [NUM_VC-1:0]       buf_full_o,
  output logic [NUM_VC*CNT_W-1:0] buf_count_o,
  output logic                    credit_valid_o,
  output logic [VC_W-1:0]         credit_vc_o,
  output logic                    overflow_o,
  output logic                    underflow_o
);
  logic [NUM_VC-1:0][DATA_WIDTH-1:0] head;
  logic [NUM_VC-1:0][CNT_W-1:0]      cnt;
  logic [NUM_VC-1:0]                 wr_en, rd_en;
  logic                              wr_vc_ok, rd_vc_ok, wr_acc, rd_acc;
  logic [1:0]                        vld_pipe;

  // Full/empty use the pre-edge count: no bypass, no write-through.
  assign wr_vc_ok = 32'(buf_wvc_i) < 32'(NUM_VC);
  assign rd_vc_ok = 32'(buf_rvc_i) < 32'(NUM_VC);
  assign wr_acc   = buf_write_i && wr_vc_ok && !buf_full_o[buf_wvc_i];
  assign rd_acc   = buf_read_i  && rd_vc_ok && !buf_empty_o[buf_rvc_i];

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign wr_en[v]       = wr_acc && (buf_wvc_i == VC_W'(v));
    assign rd_en[v]       = rd_acc && (buf_rvc_i == VC_W'(v));
    assign buf_empty_o[v] = (cnt[v] == '0);
    assign buf_full_o[v]  = (cnt[v] == CNT_W'(DEPTH));

    vc_input_buffer_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .CNT_W      (CNT_W)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .wr_en (wr_en[v]),
      .rd_en (rd_en[v]),
      .wdata (buf_data_i),
      .head  (head[v]),
      .count (cnt[v])
    );
  end

  assign buf_count_o = cnt;
  assign vld_pipe[0] = rd_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe[1]    <= 1'b0;
      buf_data_o     <= '0;
      credit_valid_o <= 1'b0;
      credit_vc_o    <= '0;
      overflow_o     <= 1'b0;
      underflow_o    <= 1'b0;
    end else begin
      vld_pipe[1]    <= vld_pipe[0];
      credit_valid_o <= vld_pipe[0];
      if (rd_acc) begin
        buf_data_o  <= head[buf_rvc_i];
        credit_vc_o <= buf_rvc_i;
      end
      if (buf_write_i && !wr_acc) overflow_o  <= 1'b1;
      if (buf_read_i  && !rd_acc) underflow_o <= 1'b1;
    end
  end

  assign buf_valid_o = vld_pipe[1];
endmodule

// File: tb/tb_vc_input_buffer.sv
// Directed table-driven bench for vc_input_buffer (DEPTH=5, NUM_VC=2).

module tb_vc_input_buffer;
  localparam int DW = 16, DEPTH = 5, NVC = 2, CW = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            buf_write_i = 1'b0, buf_read_i = 1'b0;
  logic            buf_wvc_i = 1'b0, buf_rvc_i = 1'b0;
  logic [DW-1:0]   buf_data_i = '0;
  logic [DW-1:0]   buf_data_o;
  logic            buf_valid_o, credit_valid_o, credit_vc_o, overflow_o, underflow_o;
  logic [NVC-1:0]  buf_empty_o, buf_full_o;
  logic [NVC*CW-1:0] buf_count_o;

  int n_chk = 0, n_fail = 0, vec_id = 0;

  always #5 clk = ~clk;

  vc_input_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_VC(NVC)) dut (
    .clk(clk), .reset(reset),
    .buf_write_i(buf_write_i), .buf_wvc_i(buf_wvc_i), .buf_data_i(buf_data_i),
    .buf_read_i(buf_read_i), .buf_rvc_i(buf_rvc_i),
    .buf_data_o(buf_data_o), .buf_valid_o(buf_valid_o),
    .buf_empty_o(buf_empty_o), .buf_full_o(buf_full_o), .buf_count_o(buf_count_o),
    .credit_valid_o(credit_valid_o), .credit_vc_o(credit_vc_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  typedef struct {
    bit rst; bit wr; bit wvc; logic [15:0] wd; bit rd; bit rvc;
    bit ev; logic [15:0] ed; bit ecv; bit ecvc; int c0; int c1; bit ov; bit un;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit wr, bit wvc, logic [15:0] wd, bit rd, bit rvc,
                              bit ev, logic [15:0] ed, bit ecv, bit ecvc,
                              int c0, int c1, bit ov, bit un);
    vec_t v;
    v.rst = rst; v.wr = wr; v.wvc = wvc; v.wd = wd; v.rd = rd; v.rvc = rvc;
    v.ev = ev; v.ed = ed; v.ecv = ecv; v.ecvc = ecvc;
    v.c0 = c0; v.c1 = c1; v.ov = ov; v.un = un;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %h expected %h", nm, vec_id, act, exp);
    end
  endtask

  task automatic chk_all(bit ev, logic [15:0] ed, bit ecv, bit ecvc, int c0, int c1, bit ov, bit un);
    logic [2:0] c0b, c1b;
    c0b = 3'(c0); c1b = 3'(c1);
    chk("valid",        32'(buf_valid_o),    32'(ev));
    chk("data",         32'(buf_data_o),     32'(ed));
    chk("credit_valid", 32'(credit_valid_o), 32'(ecv));
    chk("credit_vc",    32'(credit_vc_o),    32'(ecvc));
    chk("count",        32'(buf_count_o),    32'({c1b, c0b}));
    chk("empty",        32'(buf_empty_o),    32'({c1 == 0, c0 == 0}));
    chk("full",         32'(buf_full_o),     32'({c1 == DEPTH, c0 == DEPTH}));
    chk("overflow",     32'(overflow_o),     32'(ov));
    chk("underflow",    32'(underflow_o),    32'(un));
  endtask

  task automatic drive(bit wr, bit wvc, logic [15:0] wd, bit rd, bit rvc);
    buf_write_i = wr; buf_wvc_i = wvc; buf_data_i = wd;
    buf_read_i = rd;  buf_rvc_i = rvc;
  endtask

  initial begin
    // fill VC0, overflow, drain, underflow
    vecs.push_back(mk(0,1,0,16'h0001,0,0, 0,16'h0000,0,0, 1,0,0,0));
    vecs.push_back(mk(0,1,0,16'h0002,0,0, 0,16'h0000,0,0, 2,0,0,0));
    vecs.push_back(mk(0,1,0,16'h0003,0,0, 0,16'h0000,0,0, 3,0,0,0));
    vecs.push_back(mk(0,1,0,16'h0004,0,0, 0,16'h0000,0,0, 4,0,0,0));
    vecs.push_back(mk(0,1,0,16'h0005,0,0, 0,16'h0000,0,0, 5,0,0,0));
    vecs.push_back(mk(0,1,0,16'h0006,0,0, 0,16'h0000,0,0, 5,0,1,0));
    vecs.push_back(mk(0,0,0,16'h0000,1,0, 1,16'h0001,1,0, 4,0,1,0));
    vecs.push_back(mk(0,0,0,16'h0000,1,0, 1,16'h0002,1,0, 3,0,1,0));
    vecs.push_back(mk(0,0,0,16'h0000,1,0, 1,16'h0003,1,0, 2,0,1,0));
    vecs.push_back(mk(0,0,0,16'h0000,1,0, 1,16'h0004,1,0, 1,0,1,0));
    vecs.push_back(mk(0,0,0,16'h0000,1,0, 1,16'h0005,1,0, 0,0,1,0));
    vecs.push_back(mk(0,0,0,16'h0000,1,0, 0,16'h0005,0,0, 0,0,1,1));
    vecs.push_back(mk(0,0,0,16'h0000,0,0, 0,16'h0005,0,0, 0,0,1,1));
    // VC1 pointer wrap, then full + simultaneous read/write
    vecs.push_back(mk(1,1,1,16'h00B0,0,0, 0,16'h0000,0,0, 0,1,0,0));
    vecs.push_back(mk(0,1,1,16'h00B1,0,0, 0,16'h0000,0,0, 0,2,0,0));
    vecs.push_back(mk(0,1,1,16'h00B2,0,0, 0,16'h0000,0,0, 0,3,0,0));
    vecs.push_back(mk(0,0,0,16'h0000,1,1, 1,16'h00B0,1,1, 0,2,0,0));
    vecs.push_back(mk(0,0,0,16'h0000,1,1, 1,16'h00B1,1,1, 0,1,0,0));
    vecs.push_back(mk(0,0,0,16'h0000,1,1, 1,16'h00B2,1,1, 0,0,0,0));
    vecs.push_back(mk(0,1,1,16'h00A0,0,0, 0,16'h00B2,0,1, 0,1,0,0));
    vecs.push_back(mk(0,1,1,16'h00A1,0,0, 0,16'h00B2,0,1, 0,2,0,0));
    vecs.push_back(mk(0,1,1,16'h00A2,0,0, 0,16'h00B2,0,1, 0,3,0,0));
    vecs.push_back(mk(0,1,1,16'h00A3,0,0, 0,16'h00B2,0,1, 0,4,0,0));
    vecs.push_back(mk(0,1,1,16'h00A4,0,0, 0,16'h00B2,0,1, 0,5,0,0));
    vecs.push_back(mk(0,1,1,16'h00C5,1,1, 1,16'h00A0,1,1, 0,4,1,0));
    vecs.push_back(mk(0,0,0,16'h0000,1,1, 1,16'h00A1,1,1, 0,3,1,0));
    vecs.push_back(mk(0,1,1,16'h00C6,1,1, 1,16'h00A2,1,1, 0,3,1,0));
    vecs.push_back(mk(0,0,0,16'h0000,1,1, 1,16'h00A3,1,1, 0,2,1,0));
    vecs.push_back(mk(0,0,0,16'h0000,1,1, 1,16'h00A4,1,1, 0,1,1,0));
    vecs.push_back(mk(0,0,0,16'h0000,1,1, 1,16'h00C6,1,1, 0,0,1,0));
    // interleaved VCs, no write-through on empty, cross-VC read/write
    vecs.push_back(mk(1,1,0,16'h0011,0,0, 0,16'h0000,0,0, 1,0,0,0));
    vecs.push_back(mk(0,1,1,16'h0022,0,0, 0,16'h0000,0,0, 1,1,0,0));
    vecs.push_back(mk(0,1,0,16'h0033,0,0, 0,16'h0000,0,0, 2,1,0,0));
    vecs.push_back(mk(0,0,0,16'h0000,1,1, 1,16'h0022,1,1, 2,0,0,0));
    vecs.push_back(mk(0,0,0,16'h0000,1,0, 1,16'h0011,1,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,16'h0000,1,0, 1,16'h0033,1,0, 0,0,0,0));
    vecs.push_back(mk(0,1,0,16'h0044,1,0, 0,16'h0033,0,0, 1,0,0,1));
    vecs.push_back(mk(0,1,1,16'h0066,1,0, 1,16'h0044,1,0, 0,1,0,1));
    vecs.push_back(mk(0,0,0,16'h0000,1,1, 1,16'h0066,1,1, 0,0,0,1));

    // reset state
    #12;
    chk_all(0, 16'h0000, 0, 0, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b1;

    foreach (vecs[i]) begin
      vec_id = i;
      @(negedge clk);
      if (vecs[i].rst) reset = 1'b0;
      drive(vecs[i].wr, vecs[i].wvc, vecs[i].wd, vecs[i].rd, vecs[i].rvc);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      chk_all(vecs[i].ev, vecs[i].ed, vecs[i].ecv, vecs[i].ecvc,
              vecs[i].c0, vecs[i].c1, vecs[i].ov, vecs[i].un);
    end

    // async reset mid-stream with VC0 at 3 and a read strobe pending
    vec_id = 100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive(1, 0, 16'(16'h0070 + k), 0, 0);
    end
    @(negedge clk); drive(0, 0, 16'h0000, 1, 1);   // underflow on empty VC1
    @(negedge clk); drive(0, 0, 16'h0000, 1, 0);
    @(posedge clk); #1;
    chk_all(1, 16'h0070, 1, 0, 2, 0, 0, 1);
    @(negedge clk); drive(0, 0, 16'h0000, 1, 0);
    #2 reset = 1'b0;
    #1;
    vec_id = 101;
    chk_all(0, 16'h0000, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    vec_id = 102;
    chk_all(0, 16'h0000, 0, 0, 0, 0, 0, 0);
    @(negedge clk); drive(0, 0, 16'h0000, 0, 0); reset = 1'b1;
    @(negedge clk); drive(1, 0, 16'h0055, 0, 0);
    @(negedge clk); drive(0, 0, 16'h0000, 1, 0);
    @(posedge clk); #1;
    vec_id = 103;
    chk_all(1, 16'h0055, 1, 0, 0, 0, 0, 0);
    @(negedge clk); drive(0, 0, 16'h0000, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
